// File: rtl/truncate_clusters_multi.sv
// Frame-based S-bit truncator: latches a vector once per frame, then strips the lowest
// set bit (globally, or per segment) each clock so a pipelined priority encoder can follow.
module truncate_clusters_multi #(
  parameter int WIDTH   = 1536,
  parameter int MXSEGS  = 24,
  parameter int SEGSIZE = 64,
  parameter int PERIOD  = 8,
  parameter int CNTW    = 16
) (
  input  logic             i_clock,
  input  logic             i_global_reset_n,
  input  logic [WIDTH-1:0] i_vpfs_in,
  input  logic             i_parallel_mode,
  input  logic             i_sync_in,
  output logic [WIDTH-1:0] o_vpfs_out,
  output logic             o_load_out,
  output logic [3:0]       o_phase_out,
  output logic             o_empty,
  output logic             o_overflow,
  output logic [CNTW-1:0]  o_overflow_cnt
);

  localparam int NGRP = (MXSEGS + 2) / 3;
  localparam int NPAD = 3 * NGRP;
  localparam logic [3:0] LAST_PHASE = 4'(PERIOD - 1);

  logic [SEGSIZE-1:0] r_seg [MXSEGS];
  logic [3:0]         r_phase;
  logic [3:0]         r_phaseOut;
  logic               r_load;
  logic               r_overflow;
  logic [CNTW-1:0]    r_cnt;

  logic [MXSEGS-1:0]  w_segNz;
  logic [NPAD-1:0]    w_nzPad;
  logic [NPAD-1:0]    w_inGrp;
  logic [NGRP-1:0]    w_grpNz;
  logic [NGRP-1:0]    w_grpBefore;
  logic [MXSEGS-1:0]  w_keep;
  logic               w_any;
  logic               w_ld;

  // Keep chain is resolved in groups of three segments: a short serial OR over
  // group summaries, plus at most two in-group terms per segment.
  always_comb begin
    logic acc;
    w_segNz     = '0;
    w_nzPad     = '0;
    w_inGrp     = '0;
    w_grpNz     = '0;
    w_grpBefore = '0;
    w_keep      = '0;
    acc         = 1'b0;
    for (int s = 0; s < MXSEGS; s++) begin
      w_segNz[s] = |r_seg[s];
    end
    w_nzPad[MXSEGS-1:0] = w_segNz;
    for (int g = 0; g < NGRP; g++) begin
      w_grpNz[g]       = |w_nzPad[3*g +: 3];
      w_inGrp[3*g]     = 1'b0;
      w_inGrp[3*g + 1] = w_nzPad[3*g];
      w_inGrp[3*g + 2] = w_nzPad[3*g] | w_nzPad[3*g + 1];
      w_grpBefore[g]   = acc;
      acc              = acc | w_grpNz[g];
    end
    for (int s = 0; s < MXSEGS; s++) begin
      w_keep[s] = ~i_parallel_mode & (w_grpBefore[s/3] | w_inGrp[s]);
    end
  end

  assign w_any = |w_segNz;
  assign w_ld  = (r_phase == 4'd0) | i_sync_in;

  always_ff @(posedge i_clock) begin
    if (!i_global_reset_n) begin
      for (int s = 0; s < MXSEGS; s++) begin
        r_seg[s] <= '0;
      end
      r_phase    <= '0;
      r_phaseOut <= '0;
      r_load     <= 1'b0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
    end else if (w_ld) begin
      for (int s = 0; s < MXSEGS; s++) begin
        r_seg[s] <= i_vpfs_in[s*SEGSIZE +: SEGSIZE];
      end
      r_phase    <= 4'd1;
      r_phaseOut <= 4'd0;
      r_load     <= 1'b1;
      r_overflow <= w_any;
      if (w_any && !(&r_cnt)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      // x & (x-1) drops the lowest set bit and leaves zero at zero.
      for (int s = 0; s < MXSEGS; s++) begin
        r_seg[s] <= w_keep[s] ? r_seg[s] : (r_seg[s] & (r_seg[s] - 1'b1));
      end
      r_phase    <= (r_phase == LAST_PHASE) ? 4'd0 : r_phase + 1'b1;
      r_phaseOut <= r_phase;
      r_load     <= 1'b0;
      r_overflow <= 1'b0;
    end
  end

  always_comb begin
    o_vpfs_out = '0;
    for (int s = 0; s < MXSEGS; s++) begin
      o_vpfs_out[s*SEGSIZE +: SEGSIZE] = r_seg[s];
    end
  end

  assign o_load_out     = r_load;
  assign o_phase_out    = r_phaseOut;
  assign o_empty        = ~w_any;
  assign o_overflow     = r_overflow;
  assign o_overflow_cnt = r_cnt;

endmodule

// File: tb/tb_truncate_clusters_multi.sv
// Directed + scoreboard bench for truncate_clusters_multi: a bit-walking reference model
// pushes expected outputs per edge, and directed constant checks cover the named scenarios.
module tb_truncate_clusters_multi;

  localparam int WIDTH   = 1536;
  localparam int MXSEGS  = 24;
  localparam int SEGSIZE = 64;
  localparam int PERIOD  = 8;
  localparam int CNTW    = 16;

  logic             clock = 1'b0;
  logic             rstN;
  logic [WIDTH-1:0] vpfsIn;
  logic             parallelMode;
  logic             syncIn;
  logic [WIDTH-1:0] vpfsOut;
  logic             loadOut;
  logic [3:0]       phaseOut;
  logic             empty;
  logic             ovf;
  logic [CNTW-1:0]  ovfCnt;

  always #5 clock = ~clock;

  truncate_clusters_multi #(
    .WIDTH(WIDTH), .MXSEGS(MXSEGS), .SEGSIZE(SEGSIZE), .PERIOD(PERIOD), .CNTW(CNTW)
  ) dut (
    .i_clock(clock),
    .i_global_reset_n(rstN),
    .i_vpfs_in(vpfsIn),
    .i_parallel_mode(parallelMode),
    .i_sync_in(syncIn),
    .o_vpfs_out(vpfsOut),
    .o_load_out(loadOut),
    .o_phase_out(phaseOut),
    .o_empty(empty),
    .o_overflow(ovf),
    .o_overflow_cnt(ovfCnt)
  );

  typedef struct {
    logic [WIDTH-1:0] segs;
    logic             load;
    logic [3:0]       phase;
    logic             empty;
    logic             ovf;
    logic [CNTW-1:0]  cnt;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] mSegs = '0;
  int               mPhase = 0;
  logic [CNTW-1:0]  mCnt = '0;
  logic [WIDTH-1:0] expV;
  int               nCompared = 0;
  int               nMismatch = 0;

  function automatic logic [WIDTH-1:0] clearGlobal(input logic [WIDTH-1:0] v);
    logic done = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!done && v[i]) begin
        v[i] = 1'b0;
        done = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] clearPerSeg(input logic [WIDTH-1:0] v);
    logic done;
    for (int s = 0; s < MXSEGS; s++) begin
      done = 1'b0;
      for (int b = 0; b < SEGSIZE; b++) begin
        if (!done && v[s*SEGSIZE + b]) begin
          v[s*SEGSIZE + b] = 1'b0;
          done = 1'b1;
        end
      end
    end
    return v;
  endfunction

  function automatic int lowestBit(input logic [WIDTH-1:0] v);
    int idx = -1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i] === 1'b1) idx = i;
    end
    return idx;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkVec(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s observed %0d bits (lowest %0d) expected %0d bits (lowest %0d)",
             tag, $countones(obs), lowestBit(obs), $countones(exp), lowestBit(exp));
    end
  endtask

  // Advance the model with the inputs about to be sampled, queue the result, cross the edge.
  task automatic applyStimulus();
    exp_t e;
    if (!rstN) begin
      mSegs  = '0;
      mPhase = 0;
      mCnt   = '0;
      e.load = 1'b0;
      e.phase = 4'd0;
      e.ovf  = 1'b0;
    end else if (mPhase == 0 || syncIn) begin
      e.ovf = (mSegs != '0);
      if (e.ovf && mCnt != '1) mCnt = mCnt + 1'b1;
      mSegs   = vpfsIn;
      e.load  = 1'b1;
      e.phase = 4'd0;
      mPhase  = 1;
    end else begin
      e.ovf   = 1'b0;
      e.load  = 1'b0;
      e.phase = 4'(mPhase);
      mPhase  = (mPhase == PERIOD - 1) ? 0 : mPhase + 1;
      mSegs   = parallelMode ? clearPerSeg(mSegs) : clearGlobal(mSegs);
    end
    e.segs  = mSegs;
    e.empty = (mSegs == '0);
    e.cnt   = mCnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      nCompared++;
      nMismatch++;
      $error("[TB] FAIL %s observed=empty scoreboard expected=one entry", tag);
      return;
    end
    e = sb.pop_front();
    checkVec({tag, "_vpfs"}, vpfsOut, e.segs);
    checkVal({tag, "_load"}, loadOut, e.load);
    checkVal({tag, "_phase"}, phaseOut, e.phase);
    checkVal({tag, "_empty"}, empty, e.empty);
    checkVal({tag, "_ovf"}, ovf, e.ovf);
    checkVal({tag, "_cnt"}, ovfCnt, e.cnt);
  endtask

  task automatic tick(input string tag);
    applyStimulus();
    checkOutput(tag);
  endtask

  initial begin
    rstN         = 1'b0;
    vpfsIn       = '1;
    parallelMode = 1'b0;
    syncIn       = 1'b0;

    repeat (3) tick("reset");
    checkVec("reset_vpfs", vpfsOut, '0);
    checkVal("reset_empty", empty, 1);
    checkVal("reset_cnt", ovfCnt, 0);
    checkVal("reset_load", loadOut, 0);

    // Global mode, sparse bits across segments
    rstN = 1'b1;
    vpfsIn = '0; vpfsIn[3] = 1'b1; vpfsIn[70] = 1'b1; vpfsIn[1535] = 1'b1;
    tick("t2_load");
    expV = vpfsIn;
    checkVec("t2_c0", vpfsOut, expV);
    checkVal("t2_load_out", loadOut, 1);
    vpfsIn = '0;
    tick("t2_c1");
    expV = '0; expV[70] = 1'b1; expV[1535] = 1'b1;
    checkVec("t2_c1_const", vpfsOut, expV);
    tick("t2_c2");
    expV = '0; expV[1535] = 1'b1;
    checkVec("t2_c2_const", vpfsOut, expV);
    tick("t2_c3");
    checkVec("t2_c3_const", vpfsOut, '0);
    checkVal("t2_c3_empty", empty, 1);
    repeat (4) tick("t2_tail");

    // Ten bits: only seven can be removed before the next load
    vpfsIn = '0; vpfsIn[9:0] = '1;
    tick("t3_load");
    checkVal("t2_no_ovf", ovf, 0);
    checkVal("t3_pop0", $countones(vpfsOut), 10);
    for (int k = 1; k < PERIOD; k++) begin
      tick("t3_clear");
      checkVal("t3_pop", $countones(vpfsOut), 64'(10 - k));
    end

    // Per-segment mode
    parallelMode = 1'b1;
    vpfsIn = '0; vpfsIn[0] = 1'b1; vpfsIn[1] = 1'b1;
    vpfsIn[64] = 1'b1; vpfsIn[65] = 1'b1; vpfsIn[66] = 1'b1;
    tick("t4_load");
    checkVal("t3_ovf", ovf, 1);
    checkVal("t3_cnt", ovfCnt, 1);
    tick("t4_c1");
    expV = '0; expV[1] = 1'b1; expV[65] = 1'b1; expV[66] = 1'b1;
    checkVec("t4_c1_const", vpfsOut, expV);
    tick("t4_c2");
    expV = '0; expV[66] = 1'b1;
    checkVec("t4_c2_const", vpfsOut, expV);
    tick("t4_c3");
    checkVec("t4_c3_const", vpfsOut, '0);
    repeat (4) tick("t4_tail");

    // Sync mid-frame while residue remains
    parallelMode = 1'b0;
    vpfsIn = '0; vpfsIn[5:1] = '1; vpfsIn[1000] = 1'b1;
    tick("t5_load");
    checkVal("t4_no_ovf", ovf, 0);
    repeat (3) tick("t5_pre");
    checkVal("t5_bit1000", vpfsOut[1000], 1);
    checkVal("t5_pre_phase", phaseOut, 3);
    syncIn = 1'b1;
    vpfsIn = '0; vpfsIn[7] = 1'b1;
    tick("t5_sync");
    syncIn = 1'b0;
    expV = '0; expV[7] = 1'b1;
    checkVec("t5_vpfs", vpfsOut, expV);
    checkVal("t5_phase", phaseOut, 0);
    checkVal("t5_ovf", ovf, 1);
    checkVal("t5_cnt", ovfCnt, 2);

    // Random frames in both modes, with a mode flip mid-frame
    for (int f = 0; f < 4; f++) begin
      parallelMode = f[0];
      vpfsIn = '0;
      repeat (12) vpfsIn[$urandom_range(WIDTH - 1, 0)] = 1'b1;
      for (int k = 0; k < 6; k++) vpfsIn[k * SEGSIZE + 5 + f] = 1'b1;
      syncIn = 1'b1;
      tick("rnd_load");
      syncIn = 1'b0;
      repeat (3) tick("rnd_clear");
      parallelMode = ~parallelMode;
      repeat (4) tick("rnd_clear_flip");
    end

    // Reset in mid-frame with residue, then immediate load on release
    parallelMode = 1'b0;
    vpfsIn = '0; vpfsIn[63:0] = '1;
    syncIn = 1'b1;
    tick("t6_load");
    syncIn = 1'b0;
    repeat (2) tick("t6_pre");
    checkVal("t6_residue", empty, 0);
    rstN = 1'b0;
    tick("t6_reset");
    checkVec("t6_rst_vpfs", vpfsOut, '0);
    checkVal("t6_rst_cnt", ovfCnt, 0);
    checkVal("t6_rst_ovf", ovf, 0);
    rstN = 1'b1;
    vpfsIn = '0; vpfsIn[5] = 1'b1;
    tick("t6_release");
    expV = '0; expV[5] = 1'b1;
    checkVec("t6_rel_vpfs", vpfsOut, expV);
    checkVal("t6_rel_load", loadOut, 1);
    checkVal("t6_rel_ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
